flow_control_loop_pipe_seq_init: RTL and testbench

- Handshake adapter between a caller's ap_start/ap_ready/ap_done protocol and one sequential pipelined loop body (II=1, single stage), such as the vsub_row loop.
- Generates the loop-init pulse that makes the body reload its induction variable and accumulators.
- Forwards start to the body and converts the body's exit signals into caller-visible ready/done, with a sticky done.
- The loop body's element-select multiplexer (4:1, 32-bit) is the companion leaf delivered with this block.

---
 rtl/flow_control_loop_pipe_seq_init_pkg.sv | 36 +++
 rtl/mux4_w32.sv | 31 +++
 rtl/flow_control_loop_pipe_seq_init.sv | 59 +++++
 tb/tb_flow_control_loop_pipe_seq_init.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/flow_control_loop_pipe_seq_init_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flow_control_loop_pipe_seq_init_pkg
// Brief    : Shared handshake types and constants for the loop controller.
// Revision : 1.0
// ============================================================================
package flow_control_loop_pipe_seq_init_pkg;

    localparam int LOOP_DATA_W = 32;

    // Caller-facing handshake bundle.
    typedef struct packed {
        logic start;
        logic ready;
        logic done;
        logic cont;
    } hs_t;

    // Two-level priority register update: hi_cond beats lo_cond, else hold.
    function automatic logic prio_update(
        input logic hi_cond,
        input logic hi_val,
        input logic lo_cond,
        input logic lo_val,
        input logic cur
    );
        if (hi_cond) begin
            return hi_val;
        end else if (lo_cond) begin
            return lo_val;
        end
        return cur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_w32.sv
`default_nettype none
// ============================================================================
// Module   : mux4_w32
// Brief    : 4:1 element-select multiplexer, purely combinational.
// Revision : 1.0
// ============================================================================
module mux4_w32
    import flow_control_loop_pipe_seq_init_pkg::*;
#(
    parameter int DATA_W = LOOP_DATA_W
) (
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic [DATA_W-1:0] din2,
    input  logic [DATA_W-1:0] din3,
    input  logic [1:0]        sel,
    output logic [DATA_W-1:0] dout
);

    always_comb begin
        dout = din0;
        case (sel)
            2'd1:    dout = din1;
            2'd2:    dout = din2;
            2'd3:    dout = din3;
            default: dout = din0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/flow_control_loop_pipe_seq_init.sv
`default_nettype none
// ============================================================================
// Module   : flow_control_loop_pipe_seq_init
// Brief    : ap_start/ap_ready/ap_done adapter for a sequential II=1 loop body.
// Revision : 1.0
// ============================================================================
module flow_control_loop_pipe_seq_init
    import flow_control_loop_pipe_seq_init_pkg::*;
(
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic ap_start,
    output logic ap_ready,
    output logic ap_done,
    output logic ap_start_int,
    output logic ap_loop_init,
    input  logic ap_ready_int,
    input  logic ap_loop_exit_ready,
    input  logic ap_loop_exit_done,
    output logic ap_continue_int,
    input  logic ap_done_int
);

    logic r_init;
    logic r_done_cache;
    hs_t  w_caller;
    logic w_unused_done_int;

    // Body done is informational only; exit_done carries the completion.
    assign w_unused_done_int = ap_done_int;

    // Exit re-arms init so a back-to-back call starts at iteration 0.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_init       <= 1'b1;
            r_done_cache <= 1'b0;
        end else begin
            r_init       <= prio_update(ap_loop_exit_ready, 1'b1,
                                        ap_ready_int,       1'b0, r_init);
            r_done_cache <= prio_update(ap_start,          1'b0,
                                        ap_loop_exit_done, 1'b1, r_done_cache);
        end
    end

    always_comb begin
        w_caller.start = ap_start;
        w_caller.ready = ap_loop_exit_ready;
        w_caller.done  = ap_loop_exit_done | r_done_cache;
        w_caller.cont  = 1'b1;
    end

    assign ap_start_int    = w_caller.start;
    assign ap_ready        = w_caller.ready;
    assign ap_done         = w_caller.done;
    assign ap_continue_int = w_caller.cont;
    assign ap_loop_init    = r_init & ap_start;

endmodule
`default_nettype wire

// File: tb/tb_flow_control_loop_pipe_seq_init.sv
`default_nettype none
// ============================================================================
// Module   : tb_flow_control_loop_pipe_seq_init
// Brief    : Scoreboard bench for the loop controller and its 4:1 select mux.
// Revision : 1.0
// ============================================================================
module tb_flow_control_loop_pipe_seq_init;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_start_int;
    logic        ap_loop_init;
    logic        ap_ready_int;
    logic        ap_loop_exit_ready;
    logic        ap_loop_exit_done;
    logic        ap_continue_int;
    logic        ap_done_int;
    logic [31:0] din0, din1, din2, din3, dout;
    logic [1:0]  sel;

    typedef struct {
        string       name;
        logic [4:0]  ctl;
        bit          chk_mux;
        logic [31:0] dout;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    logic [31:0] mux_tbl [4];

    flow_control_loop_pipe_seq_init u_dut (
        .ap_clk             (ap_clk),
        .ap_rst_n           (ap_rst_n),
        .ap_start           (ap_start),
        .ap_ready           (ap_ready),
        .ap_done            (ap_done),
        .ap_start_int       (ap_start_int),
        .ap_loop_init       (ap_loop_init),
        .ap_ready_int       (ap_ready_int),
        .ap_loop_exit_ready (ap_loop_exit_ready),
        .ap_loop_exit_done  (ap_loop_exit_done),
        .ap_continue_int    (ap_continue_int),
        .ap_done_int        (ap_done_int)
    );

    mux4_w32 #(.DATA_W(32)) u_mux (
        .din0 (din0),
        .din1 (din1),
        .din2 (din2),
        .din3 (din3),
        .sel  (sel),
        .dout (dout)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors pending", q_exp.size());
        $fatal(1, "watchdog");
    end

    // One cycle of stimulus; expected {ready, done, init} hand-computed per step.
    task automatic step(input string nm, input logic rst_n, input logic s,
                        input logic ri, input logic er, input logic ed,
                        input logic e_rdy, input logic e_done, input logic e_init);
        exp_t e;
        @(posedge ap_clk);
        #1;
        ap_rst_n           = rst_n;
        ap_start           = s;
        ap_ready_int       = ri;
        ap_loop_exit_ready = er;
        ap_loop_exit_done  = ed;
        ap_done_int        = ed;
        e.name    = nm;
        e.ctl     = {e_rdy, e_done, e_init, s, 1'b1};
        e.chk_mux = 1'b0;
        e.dout    = '0;
        q_exp.push_back(e);
        n_push++;
    endtask

    task automatic mux_step(input string nm, input logic [1:0] s_sel, input logic [31:0] e_dout);
        exp_t e;
        @(posedge ap_clk);
        #1;
        sel       = s_sel;
        e.name    = nm;
        e.ctl     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        e.chk_mux = 1'b1;
        e.dout    = e_dout;
        q_exp.push_back(e);
        n_push++;
    endtask

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    initial begin
        exp_t e;
        logic [4:0] act;
        forever begin
            @(negedge ap_clk);
            if (q_exp.size() > 0) begin
                e   = q_exp.pop_front();
                act = {ap_ready, ap_done, ap_loop_init, ap_start_int, ap_continue_int};
                n_vec++;
                if (act !== e.ctl) begin
                    n_bad++;
                    $display("FAIL %s: ready/done/init/start_int/cont = %b, expected %b",
                             e.name, act, e.ctl);
                end
                if (e.chk_mux && (dout !== e.dout)) begin
                    n_bad++;
                    $display("FAIL %s: dout = %h, expected %h", e.name, dout, e.dout);
                end
            end
        end
    end

    initial begin
        ap_rst_n = 1'b0; ap_start = 1'b0; ap_ready_int = 1'b0;
        ap_loop_exit_ready = 1'b0; ap_loop_exit_done = 1'b0; ap_done_int = 1'b0;
        din0 = 32'h0000_0001; din1 = 32'h7FFF_FFFF;
        din2 = 32'h8000_0000; din3 = 32'hFFFF_FFFF;
        mux_tbl[0] = 32'h0000_0001; mux_tbl[1] = 32'h7FFF_FFFF;
        mux_tbl[2] = 32'h8000_0000; mux_tbl[3] = 32'hFFFF_FFFF;
        sel = 2'd0;

        //   name          rst s  ri er ed   rdy done init
        step("rst_idle",   0, 0, 0, 0, 0,   0, 0, 0);
        step("rst_start",  0, 1, 0, 0, 0,   0, 0, 1);
        step("idle",       1, 0, 0, 0, 0,   0, 0, 0);
        // Four compute iterations, exit in the fifth cycle.
        step("call_c1",    1, 1, 1, 0, 0,   0, 0, 1);
        for (int i = 2; i <= 4; i++)
            step("call_cN",1, 1, 1, 0, 0,   0, 0, 0);
        step("call_exit",  1, 1, 1, 1, 1,   1, 1, 0);
        // Start held through exit: back-to-back call re-inits.
        step("b2b_init",   1, 1, 1, 0, 0,   0, 0, 1);
        step("b2b_c2",     1, 1, 1, 0, 0,   0, 0, 0);
        step("stall",      1, 0, 0, 0, 0,   0, 0, 0);
        step("resume",     1, 1, 1, 0, 0,   0, 0, 0);
        step("b2b_c4",     1, 1, 1, 0, 0,   0, 0, 0);
        step("exit_slow",  1, 0, 0, 1, 1,   1, 1, 0);
        for (int i = 0; i < 10; i++)
            step("sticky",  1, 0, 0, 0, 0,   0, 1, 0);
        step("restart",    1, 1, 1, 0, 0,   0, 1, 1);
        step("done_clr",   1, 1, 1, 0, 0,   0, 0, 0);
        step("simult",     1, 1, 1, 1, 0,   1, 0, 0);
        step("rearm",      1, 1, 1, 0, 0,   0, 0, 1);
        step("iter2",      1, 1, 1, 0, 0,   0, 0, 0);
        step("xdone_only", 1, 0, 0, 0, 1,   0, 1, 0);
        step("hold_done",  1, 0, 0, 0, 0,   0, 1, 0);
        // Reset applied mid-cycle: state clears without waiting for an edge.
        step("async_rst",  0, 1, 1, 0, 0,   0, 0, 1);
        step("post_rst",   1, 1, 1, 0, 0,   0, 0, 1);
        step("post_c2",    1, 1, 1, 0, 0,   0, 0, 0);
        step("quiet",      1, 0, 0, 0, 0,   0, 0, 0);

        for (int k = 0; k < 4; k++)
            mux_step("mux_sweep", 2'(k), mux_tbl[k]);
        mux_step("mux_back", 2'd1, 32'h7FFF_FFFF);

        for (int t = 0; t < 20 && q_exp.size() > 0; t++)
            @(negedge ap_clk);
        #1;
        if (q_exp.size() != 0 || n_vec != n_push) begin
            n_bad++;
            $display("FAIL drain: checked %0d of %0d vectors", n_vec, n_push);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
